// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states,
// default datapath width and requester indices.
package arb_pkg;

    localparam int unsigned ARB_DATA_W = 64;

    // Requester indices, also the values carried by grant_sel and prio.
    localparam logic REQ_IFETCH = 1'b0;
    localparam logic REQ_DATA   = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_2to1.sv
// Generic 2-to-1 multiplexer; sel=0 passes a, sel=1 passes b.
module mux_2to1 #(
    parameter int unsigned W = 64
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Select between the two inputs.
    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction
// fetch (m0) and data access (m1). Grant is registered and held for the
// whole transfer, priority alternates after each completed or timed-out
// transfer, and a stalled slave is released after TIMEOUT_CYC cycles.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W      = ARB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    output logic              m1_ack,
    output logic              s_req,
    output logic [DATA_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              grant_sel,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             prio;
    logic [CNT_W-1:0] hold_cnt;

    logic in_busy;
    logic req_g;
    logic we_g;
    logic any_req;
    logic pick;
    logic done;
    logic expire;
    logic abort;

    // Shared address and write-data muxes steered by the registered grant.
    mux_2to1 #(.W(DATA_W)) u_addr_mux (
        .sel (grant_sel),
        .a   (m0_addr),
        .b   (m1_addr),
        .y   (s_addr)
    );

    mux_2to1 #(.W(DATA_W)) u_wdata_mux (
        .sel (grant_sel),
        .a   (m0_wdata),
        .b   (m1_wdata),
        .y   (s_wdata)
    );

    // Transfer-ending conditions; completion takes precedence over timeout,
    // and timeout over abort.
    always_comb begin
        in_busy = (state == ARB_BUSY);
        req_g   = (grant_sel == REQ_DATA) ? m1_req : m0_req;
        we_g    = (grant_sel == REQ_DATA) ? m1_we  : m0_we;
        any_req = m0_req | m1_req;
        pick    = (m0_req & m1_req) ? prio : (m1_req ? REQ_DATA : REQ_IFETCH);
        done    = in_busy & s_ack;
        expire  = in_busy & ~s_ack & (hold_cnt == CNT_W'(TIMEOUT_CYC - 1));
        abort   = in_busy & ~s_ack & ~expire & ~req_g;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (any_req) state_nxt = ARB_BUSY;
            ARB_BUSY: if (done | expire | abort) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Grant, priority and saturating hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_sel <= REQ_IFETCH;
            prio      <= REQ_IFETCH;
            hold_cnt  <= '0;
        end else if (state == ARB_IDLE) begin
            if (any_req) begin
                grant_sel <= pick;
                hold_cnt  <= '0;
            end
        end else begin
            if (done | expire) begin
                prio <= ~grant_sel;
            end
            if (!s_ack && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Output decode.
    always_comb begin
        busy        = in_busy;
        s_req       = in_busy & req_g;
        s_we        = in_busy & req_g & we_g;
        m0_ack      = done & (grant_sel == REQ_IFETCH);
        m1_ack      = done & (grant_sel == REQ_DATA);
        timeout_err = expire;
        m_rdata     = s_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level
// model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [DW-1:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic          m0_ack, m1_ack;
    logic          s_req, s_we, s_ack = 1'b0;
    logic [DW-1:0] s_addr, s_wdata, m_rdata, s_rdata = '0;
    logic          grant_sel, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    // Model: owner of the port (-1 = nobody), which requester is preferred on
    // a tie, how many busy cycles the current grant has used.
    int own;
    bit gsel;
    bit pref;
    int cyc;
    bit stall;
    bit fin0, fin1;

    mem_port_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_ack(m1_ack),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_ack(s_ack), .s_rdata(s_rdata), .m_rdata(m_rdata),
        .grant_sel(grant_sel), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        own = -1; gsel = 1'b0; pref = 1'b0; cyc = 0; stall = 1'b0;
        fin0 = 1'b0; fin1 = 1'b0;
    endtask

    // Advance the model over one rising edge using the inputs presented.
    task automatic model_update();
        bit rg;
        fin0 = 1'b0; fin1 = 1'b0;
        if (own < 0) begin
            if (m0_req || m1_req) begin
                if (m0_req && m1_req) own = pref ? 1 : 0;
                else                  own = m1_req ? 1 : 0;
                gsel  = (own == 1);
                cyc   = 0;
                stall = ($urandom % 6 == 0);
            end
        end else begin
            rg = gsel ? m1_req : m0_req;
            if (s_ack || cyc == TO - 1) begin
                pref = !gsel;
                if (gsel) fin1 = 1'b1; else fin0 = 1'b1;
                own = -1;
            end else if (!rg) begin
                own = -1;
            end else begin
                cyc++;
            end
        end
    endtask

    // Compare every output against what the model says it must be now.
    task automatic check();
        bit b, rg, wg;
        #1;
        b  = (own >= 0);
        rg = gsel ? m1_req : m0_req;
        wg = gsel ? m1_we : m0_we;
        cmp("busy", busy, b);
        cmp("grant_sel", grant_sel, gsel);
        cmp("s_req", s_req, b && rg);
        cmp("s_we", s_we, b && rg && wg);
        cmp("s_addr", s_addr, gsel ? m1_addr : m0_addr);
        cmp("s_wdata", s_wdata, gsel ? m1_wdata : m0_wdata);
        cmp("m_rdata", m_rdata, s_rdata);
        cmp("m0_ack", m0_ack, b && !gsel && s_ack);
        cmp("m1_ack", m1_ack, b && gsel && s_ack);
        cmp("timeout_err", timeout_err, b && !s_ack && cyc == TO - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
        model_reset();
        check();
        @(negedge clk);
        rst_n = 1'b1;
        check();
    endtask

    // Randomized requester/slave behaviour driven from the model's view.
    task automatic rand_stim();
        if (fin0 || !m0_req) begin
            m0_req = (fin0 ? ($urandom % 2) : ($urandom % 3 == 0));
            m0_addr = {$urandom, $urandom}; m0_wdata = {$urandom, $urandom}; m0_we = $urandom % 2;
        end else if (own == 0 && $urandom % 25 == 0) begin
            m0_req = 1'b0;
        end
        if (fin1 || !m1_req) begin
            m1_req = (fin1 ? ($urandom % 2) : ($urandom % 3 == 0));
            m1_addr = {$urandom, $urandom}; m1_wdata = {$urandom, $urandom}; m1_we = $urandom % 2;
        end else if (own == 1 && $urandom % 25 == 0) begin
            m1_req = 1'b0;
        end
        s_rdata = {$urandom, $urandom};
        if (own >= 0)
            s_ack = ((gsel ? m1_req : m0_req) && !stall && ($urandom % 3 == 0));
        else
            s_ack = ($urandom % 4 == 0);
    endtask

    initial begin
        int n;
        model_reset();

        // Single requester m0.
        do_reset();
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_sreq", s_req, 1'b0);
        cmp("rst_gsel", grant_sel, 1'b0);
        m0_req = 1'b1; m0_addr = 64'h0000_0000_0000_1000;
        check();
        tick(); check();
        cmp("t1_gsel", grant_sel, 1'b0);
        cmp("t1_sreq", s_req, 1'b1);
        cmp("t1_saddr", s_addr, 64'h1000);
        tick(); check();
        tick(); s_ack = 1'b1; check();
        cmp("t1_ack", m0_ack, 1'b1);
        tick(); m0_req = 1'b0; s_ack = 1'b0; check();
        cmp("t1_idle", busy, 1'b0);

        // Both requesting: strict alternation, one idle cycle between grants.
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 64'h2000; m1_addr = 64'hAAAA_AAAA_AAAA_AAAA;
        m0_we = 1'b0; m1_we = 1'b1;
        check();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (busy !== 1'b1 && n < 10) begin tick(); check(); n++; end
            cmp("t2_gap", n, 1);
            cmp("t2_gsel", grant_sel, k % 2);
            if (k % 2 == 1) begin
                cmp("t2_saddr", s_addr, 64'hAAAA_AAAA_AAAA_AAAA);
                cmp("t2_swe", s_we, 1'b1);
            end
            s_ack = 1'b1; check();
            tick(); s_ack = 1'b0; check();
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;

        // Write data and read data passthrough.
        do_reset();
        m1_req = 1'b1; m1_we = 1'b1; m1_wdata = 64'h1234_5678_9ABC_DEF0;
        s_rdata = 64'hFEDC_BA98_7654_3210;
        check();
        tick(); check();
        cmp("t3_wdata", s_wdata, 64'h1234_5678_9ABC_DEF0);
        cmp("t3_rdata", m_rdata, 64'hFEDC_BA98_7654_3210);
        cmp("t3_ack0", m0_ack, 1'b0);
        tick(); s_ack = 1'b1; check();
        cmp("t3_ack1", m1_ack, 1'b1);
        cmp("t3_ack0b", m0_ack, 1'b0);
        tick(); m1_req = 1'b0; m1_we = 1'b0; s_ack = 1'b0; check();

        // Timeout on m0 with m1 pending.
        do_reset();
        m0_req = 1'b1; check();
        tick(); m1_req = 1'b1; check();
        n = 1;
        while (timeout_err !== 1'b1 && n < 40) begin tick(); check(); n++; end
        cmp("t4_cycles", n, 16);
        cmp("t4_noack", m0_ack, 1'b0);
        tick(); check();
        cmp("t4_idle", busy, 1'b0);
        tick(); check();
        cmp("t4_busy", busy, 1'b1);
        cmp("t4_gsel", grant_sel, 1'b1);
        s_ack = 1'b1; check();
        tick(); m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0; check();

        // Abort by m1; priority stays with m0.
        do_reset();
        m1_req = 1'b1; check();
        tick(); check();
        cmp("t5_gsel", grant_sel, 1'b1);
        m1_req = 1'b0; check();
        tick(); check();
        cmp("t5_idle", busy, 1'b0);
        cmp("t5_noack", m1_ack, 1'b0);
        m0_req = 1'b1; m1_req = 1'b1; check();
        tick(); check();
        cmp("t5_prio", grant_sel, 1'b0);
        s_ack = 1'b1; check();
        tick(); m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0; check();

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        m1_req = 1'b1; m1_addr = 64'h55; check();
        tick(); check();
        cmp("t6_pre", busy, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        cmp("t6_sreq", s_req, 1'b0);
        cmp("t6_busy", busy, 1'b0);
        cmp("t6_gsel", grant_sel, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; m1_req = 1'b0; s_ack = 1'b1; check();
        cmp("t6_noack", m1_ack, 1'b0);
        tick(); check();
        s_ack = 1'b0;

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_stim();
            check();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares one 64-bit memory port between instruction fetch (m0) and data access (m1).
- Holds a registered grant for the whole transfer.
- Drives the select of the shared address and write-data 2-to-1 muxes.
- Applies round-robin priority and releases a stalled slave after a timeout.

Parameters:
- DATA_W, 64, width of address and write/read data.
- TIMEOUT_CYC, 16, maximum BUSY cycles without s_ack before forced release (range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  requester 0 request, held high until m0_ack or abort.
- m0_addr  input  DATA_W  requester 0 address.
- m0_wdata  input  DATA_W  requester 0 write data.
- m0_we  input  1  requester 0 write enable.
- m0_ack  output  1  requester 0 transfer-complete pulse.
- m1_req, m1_addr, m1_wdata, m1_we, m1_ack  same as m0_* for requester 1.
- s_req  output  1  shared-port request.
- s_addr  output  DATA_W  muxed address.
- s_wdata  output  DATA_W  muxed write data.
- s_we  output  1  muxed write enable.
- s_ack  input  1  shared-port completion.
- s_rdata  input  DATA_W  shared-port read data.
- m_rdata  output  DATA_W  read data, broadcast to both requesters.
- grant_sel  output  1  registered grant; 0 = m0, 1 = m1.
- busy  output  1  high while in BUSY.
- timeout_err  output  1  one-cycle pulse on forced release.

Behaviour:
- States: IDLE, BUSY. Registered internals: grant_sel, prio (next preferred requester), hold_cnt.
- Reset (async, rst_n=0):
  - state=IDLE, grant_sel=0, prio=0, hold_cnt=0.
  - s_req=0, m0_ack=0, m1_ack=0, busy=0, timeout_err=0.
  - Reset asserted mid-transfer abandons the transfer silently; no ack is issued.
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester indexed by prio.
  - On grant, the next edge sets grant_sel and moves to BUSY with hold_cnt=0.
  - If no req is high, stay in IDLE.
  - s_ack in IDLE is ignored.
- BUSY:
  - s_req = req of the granted requester (combinational).
  - s_addr and s_wdata come from the muxes selected by grant_sel; s_we = granted we AND s_req.
  - Latency: a req first seen high in IDLE at edge N gives s_req high in the cycle after edge N.
- Completion:
  - When s_ack=1 in BUSY, the granted m*_ack is high in the same cycle (combinational from s_ack).
  - The next edge moves to IDLE with prio = ~grant_sel.
  - There is one mandatory IDLE cycle between grants.
- Abort: if the granted req falls before s_ack, the next edge moves to IDLE with no ack and prio unchanged.
- Timeout:
  - hold_cnt increments each BUSY cycle without s_ack.
  - When hold_cnt == TIMEOUT_CYC-1 and s_ack=0: timeout_err=1 for that cycle, no m*_ack, the next edge moves to IDLE, and prio = ~grant_sel.
  - If s_ack and the timeout coincide, completion wins and timeout_err=0.
- Non-granted requester: its ack is always 0; its req is held off while the other is granted.
- m_rdata = s_rdata, unregistered.
- hold_cnt width is $clog2(TIMEOUT_CYC)+1; it saturates and never wraps.
- grant_sel holds its last value in IDLE.

Decomposition:
- Package arb_pkg: state encoding (ARB_IDLE=1'b0, ARB_BUSY=1'b1), the DATA_W default, and requester index constants REQ_IFETCH=0, REQ_DATA=1.
- Sub-modules: two instances of the existing mux_2to1 (address, write data), sel=grant_sel. The FSM and counter stay in the top module.

Test Plan:
- Reset, then m0_req=1 (addr 0x0000000000001000) only:
  - grant_sel=0, s_req=1, s_addr=0x1000 one cycle later.
  - s_ack=1 after 3 cycles gives m0_ack pulse, then IDLE.
- m0_req and m1_req both high from reset (prio=0):
  - m0 served first; after its ack and one IDLE cycle, grant_sel=1.
  - s_addr=m1_addr=0xAAAAAAAAAAAAAAAA, s_we=m1_we=1.
  - Then m0 again: strict alternation over 4 transfers.
- Write passthrough:
  - m1 granted, m1_wdata=0x123456789ABCDEF0 gives s_wdata equal to it.
  - s_rdata=0xFEDCBA9876543210 gives m_rdata equal to it.
  - m0_ack stays 0 throughout.
- Timeout, TIMEOUT_CYC=16, s_ack held 0 after grant to m0:
  - timeout_err pulses in the 16th BUSY cycle, no m0_ack, busy falls next cycle.
  - A pending m1 is granted next.
- Abort: m1 granted, m1_req dropped before s_ack gives IDLE next cycle, no ack, prio unchanged.
- rst_n pulled low mid-BUSY (asynchronously, between edges): s_req, busy and grant_sel go to 0 immediately; no ack after release.
